// File: rtl/xalu_pkg.sv
// xalu_pkg: op encodings, controller state type and default timing constants shared by the XALU controller.
package xalu_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5,
        OP_MFHI  = 3'd6,
        OP_MFLO  = 3'd7
    } xalu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    localparam int TIMEOUT_DEFAULT = 64;
    localparam int GRACE_DEFAULT   = 1;

    function automatic logic is_long_op(input logic [2:0] op);
        return ~op[2];
    endfunction

    function automatic logic is_read_op(input logic [2:0] op);
        return op == OP_MFHI || op == OP_MFLO;
    endfunction

endpackage

// File: rtl/xalu_ctrl.sv
// xalu_ctrl: sequences mult/div/move requests from the pipeline into the XALU and returns HI/LO reads.
module xalu_ctrl
    import xalu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
    parameter int GRACE_CYCLES   = GRACE_DEFAULT
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        req_valid,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic        req_ready,
    output logic        Stall,
    output logic [1:0]  Start,
    output logic [2:0]  XALUOp,
    output logic [31:0] RD1,
    output logic [31:0] RD2,
    input  logic        Busy,
    input  logic [31:0] HI,
    input  logic [31:0] LO,
    output logic        rd_valid,
    output logic [31:0] rd_data,
    output logic        err
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    state_e        state_q, state_d;
    logic [2:0]    op_q, op_d;
    logic [31:0]   a_q, a_d, b_q, b_d, rd_data_q, rd_data_d;
    logic          start_q, start_d, rd_valid_q, rd_valid_d, err_q, err_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          accept, grace_done, timeout;

    assign req_ready  = state_q == ST_IDLE && !Busy;
    assign Stall      = req_valid & ~req_ready;
    assign accept     = req_valid & req_ready;
    assign grace_done = int'(cnt_q) >= GRACE_CYCLES;
    assign timeout    = int'(cnt_q) + 1 >= TIMEOUT_CYCLES;

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        cnt_d      = '0;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
        err_d      = err_q;
        case (state_q)
            ST_IDLE: begin
                if (accept && is_read_op(req_op)) begin
                    rd_valid_d = 1'b1;
                    rd_data_d  = req_op == OP_MFHI ? HI : LO;
                end else if (accept) begin
                    state_d = ST_ISSUE;
                    op_d    = req_op;
                    a_d     = req_a;
                    b_d     = req_b;
                end
            end
            ST_ISSUE: state_d = is_long_op(op_q) ? ST_WAIT : ST_IDLE;
            ST_WAIT: begin
                // Busy may still read low right after Start, so it is ignored until the grace window passes
                if (!Busy && grace_done) begin
                    state_d = ST_IDLE;
                end else if (timeout) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        start_d = state_d == ST_ISSUE;
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q    <= ST_IDLE;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            start_q    <= 1'b0;
            cnt_q      <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            start_q    <= start_d;
            cnt_q      <= cnt_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            err_q      <= err_d;
        end
    end

    assign Start    = {1'b0, start_q};
    assign XALUOp   = op_q;
    assign RD1      = a_q;
    assign RD2      = b_q;
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign err      = err_q;

endmodule

// File: tb/tb_xalu_ctrl.sv
// tb_xalu_ctrl: directed checks of xalu_ctrl against a behavioural XALU with 5-cycle mult/div latency.
module tb_xalu_ctrl;
    import xalu_pkg::*;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic        req_valid = 1'b0;
    logic [2:0]  req_op = '0;
    logic [31:0] req_a = '0, req_b = '0;
    logic        req_ready, Stall, Busy, rd_valid, err;
    logic [1:0]  Start;
    logic [2:0]  XALUOp;
    logic [31:0] RD1, RD2, rd_data;
    logic [31:0] hi_m = '0, lo_m = '0, hi_p = '0, lo_p = '0;
    logic        force_busy = 1'b0;
    int          busy_cnt = 0;
    int          start_cnt = 0;
    int          exp_starts = 0;
    int          passed = 0;
    int          total = 0;

    xalu_ctrl dut (
        .Clock(Clock), .Reset(Reset),
        .req_valid(req_valid), .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .Stall(Stall),
        .Start(Start), .XALUOp(XALUOp), .RD1(RD1), .RD2(RD2),
        .Busy(Busy), .HI(hi_m), .LO(lo_m),
        .rd_valid(rd_valid), .rd_data(rd_data), .err(err)
    );

    always #5 Clock = ~Clock;

    assign Busy = busy_cnt != 0 || force_busy;

    // Behavioural XALU: mult/div busy for 5 cycles then commit, moves write immediately
    always @(posedge Clock) begin
        if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
            if (busy_cnt == 1) begin
                hi_m <= hi_p;
                lo_m <= lo_p;
            end
        end
        if (Start == 2'd1) begin
            start_cnt <= start_cnt + 1;
            case (XALUOp)
                3'd0: {hi_p, lo_p} <= $signed({{32{RD1[31]}}, RD1}) * $signed({{32{RD2[31]}}, RD2});
                3'd1: {hi_p, lo_p} <= {32'b0, RD1} * {32'b0, RD2};
                3'd2: begin
                    lo_p <= $signed(RD1) / $signed(RD2);
                    hi_p <= $signed(RD1) % $signed(RD2);
                end
                3'd3: begin
                    lo_p <= RD1 / RD2;
                    hi_p <= RD1 % RD2;
                end
                3'd4: hi_m <= RD1;
                3'd5: lo_m <= RD1;
                default: ;
            endcase
            if (XALUOp < 3'd4) busy_cnt <= 5;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, got, exp);
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    task automatic req(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        for (int i = 0; i < 200 && !req_ready; i++) step();
        chk("accept_bound", 32'(req_ready), 32'd1);
        step();
        req_valid = 1'b0;
        req_op    = 3'($urandom);
        if (op < 3'd6) exp_starts++;
    endtask

    task automatic rd(input logic [2:0] op, input logic [31:0] exp, input string tag);
        req(op, 32'hDEAD_BEEF, 32'hCAFE_F00D);
        chk({tag, "_valid"}, 32'(rd_valid), 32'd1);
        chk(tag, rd_data, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        step(2);
        chk("rst_start", 32'(Start), 32'd0);
        chk("rst_op", 32'(XALUOp), 32'd0);
        chk("rst_rd1", RD1, 32'd0);
        chk("rst_rd2", RD2, 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd_data", rd_data, 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd1);
        Reset = 1'b1;
        step();

        // mult -7 * 13
        req(3'd0, 32'hFFFF_FFF9, 32'h0000_000D);
        chk("mult_start", 32'(Start), 32'd1);
        chk("mult_op", 32'(XALUOp), 32'd0);
        chk("mult_rd1", RD1, 32'hFFFF_FFF9);
        chk("mult_rd2", RD2, 32'h0000_000D);
        req_valid = 1'b1;
        req_op    = 3'd7;
        step();
        chk("mult_start_once", 32'(Start), 32'd0);
        chk("mult_stall", 32'(Stall), 32'd1);
        chk("mult_rd1_hold", RD1, 32'hFFFF_FFF9);
        rd(3'd7, 32'hFFFF_FFA5, "mult_lo");
        rd(3'd6, 32'hFFFF_FFFF, "mult_hi");
        step();
        chk("rd_valid_pulse", 32'(rd_valid), 32'd0);
        chk("mult_starts", 32'(start_cnt), 32'(exp_starts));

        // div 8 / 3 and divu -8 / 3
        req(3'd2, 32'd8, 32'd3);
        rd(3'd7, 32'd2, "div_lo");
        rd(3'd6, 32'd2, "div_hi");
        req(3'd3, 32'hFFFF_FFF8, 32'd3);
        rd(3'd7, 32'h5555_5552, "divu_lo");
        rd(3'd6, 32'd2, "divu_hi");

        // mthi then mfhi in the first IDLE cycle
        req(3'd4, 32'h100, 32'd0);
        chk("mthi_start", 32'(Start), 32'd1);
        step();
        chk("mthi_no_wait", 32'(req_ready), 32'd1);
        rd(3'd6, 32'h100, "mthi_back");

        // request while Busy is high
        force_busy = 1'b1;
        req_valid  = 1'b1;
        req_op     = 3'd5;
        req_a      = 32'h1234;
        step(3);
        chk("busy_stall", 32'(Stall), 32'd1);
        chk("busy_no_start", 32'(Start), 32'd0);
        chk("busy_starts", 32'(start_cnt), 32'(exp_starts));
        force_busy = 1'b0;
        #1;
        chk("busy_release_ready", 32'(req_ready), 32'd1);
        req(3'd5, 32'h1234, 32'd0);
        chk("busy_start", 32'(Start), 32'd1);
        chk("busy_rd1", RD1, 32'h1234);
        step();
        rd(3'd7, 32'h1234, "mtlo_back");

        // Busy stuck high: 64 WAIT cycles then timeout
        req(3'd0, 32'd2, 32'd3);
        force_busy = 1'b1;
        step();
        step(63);
        chk("to_err_early", 32'(err), 32'd0);
        step();
        chk("to_err", 32'(err), 32'd1);
        chk("to_ready_low", 32'(req_ready), 32'd0);
        step(5);
        chk("to_ready_still_low", 32'(req_ready), 32'd0);
        force_busy = 1'b0;
        #1;
        chk("to_ready_idle", 32'(req_ready), 32'd1);
        step(2);
        chk("to_err_sticky", 32'(err), 32'd1);

        // reset asserted mid-WAIT
        req(3'd2, 32'd8, 32'd3);
        step(2);
        #2 Reset = 1'b0;
        #1;
        chk("arst_start", 32'(Start), 32'd0);
        chk("arst_op", 32'(XALUOp), 32'd0);
        chk("arst_rd1", RD1, 32'd0);
        chk("arst_rd2", RD2, 32'd0);
        chk("arst_rd_data", rd_data, 32'd0);
        chk("arst_err", 32'(err), 32'd0);
        step();
        Reset = 1'b1;
        chk("arst_ready_busy", 32'(req_ready), 32'd0);
        for (int i = 0; i < 50 && !req_ready; i++) step();
        chk("arst_ready_bound", 32'(req_ready), 32'd1);
        step(3);
        chk("arst_no_spurious", 32'(start_cnt), 32'(exp_starts));
        rd(3'd7, 32'd2, "arst_lo");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
